// File: rtl/cpu_pkg.sv
// Shared encodings for the hardwired control unit: ALU codes, opcodes,
// FSM states and the opcode-to-ALU mapping.
package cpu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_NOT = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_NEG = 4'd5,
      ALU_SHR = 4'd6,
      ALU_SHL = 4'd7,
      ALU_ROR = 4'd8,
      ALU_ROL = 4'd9,
      ALU_MUL = 4'd10,
      ALU_DIV = 4'd11
   } alu_op_t;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_SHR  = 5'b00100;
   localparam logic [4:0] OP_SHL  = 5'b00101;
   localparam logic [4:0] OP_ROR  = 5'b00110;
   localparam logic [4:0] OP_ROL  = 5'b00111;
   localparam logic [4:0] OP_MUL  = 5'b01000;
   localparam logic [4:0] OP_DIV  = 5'b01001;
   localparam logic [4:0] OP_NEG  = 5'b01010;
   localparam logic [4:0] OP_NOT  = 5'b01011;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RESET  = 4'd0,
      ST_T0     = 4'd1,
      ST_T1     = 4'd2,
      ST_T2     = 4'd3,
      ST_T3     = 4'd4,
      ST_T4     = 4'd5,
      ST_T5     = 4'd6,
      ST_T6     = 4'd7,
      ST_HALTED = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU2   = 3'd0,
      CLS_UNARY  = 3'd1,
      CLS_MULDIV = 3'd2,
      CLS_NOP    = 3'd3,
      CLS_HALT   = 3'd4
   } op_class_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU2;
         OP_NOT, OP_NEG:                 return CLS_UNARY;
         OP_MUL, OP_DIV:                 return CLS_MULDIV;
         OP_HALT:                        return CLS_HALT;
         default:                        return CLS_NOP;
      endcase
   endfunction

   function automatic alu_op_t op_alu(input logic [4:0] op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_SHR:  return ALU_SHR;
         OP_SHL:  return ALU_SHL;
         OP_ROR:  return ALU_ROR;
         OP_ROL:  return ALU_ROL;
         OP_MUL:  return ALU_MUL;
         OP_DIV:  return ALU_DIV;
         OP_NEG:  return ALU_NEG;
         OP_NOT:  return ALU_NOT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// One-hot register select decoder: 4-bit index to NUM_REGS lines, all-zero
// when disabled or when the index is beyond the register file.
module reg_select #(
   parameter int NUM_REGS = 16
) (
   input  logic                en,
   input  logic [3:0]          idx,
   output logic [NUM_REGS-1:0] sel
);

   always_comb begin
      sel = '0;
      if (en && (int'(idx) < NUM_REGS))
         sel[idx] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, then execute steps chosen by the IR
// opcode; outputs are a Moore decode of the state plus IR register fields.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                clock,
   input  logic                clear,
   input  logic [31:0]         IR,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                PCin,
   output logic                PCout,
   output logic                MARin,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                Zlowin,
   output logic                Zhighin,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                HIin,
   output logic                LOin,
   output logic                IncPC,
   output logic                Read,
   output logic [3:0]          ALUop,
   output logic                Run
);

   state_t     state;
   op_class_t  cls;
   logic [3:0] ra, rb, rc;
   logic       rin_en, rout_en;
   logic [3:0] rin_idx, rout_idx;
   logic       ir_unused;

   assign cls       = op_class(IR[31:27]);
   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign ir_unused = ^IR[14:0];

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= ST_RESET;
      end else begin
         case (state)
            ST_RESET: state <= ST_T0;
            ST_T0:    state <= ST_T1;
            ST_T1:    state <= ST_T2;
            ST_T2:    state <= ST_T3;
            ST_T3: begin
               if (cls == CLS_HALT)     state <= ST_HALTED;
               else if (cls == CLS_NOP) state <= ST_T0;
               else                     state <= ST_T4;
            end
            ST_T4:    state <= (cls == CLS_UNARY)  ? ST_T0 : ST_T5;
            ST_T5:    state <= (cls == CLS_MULDIV) ? ST_T6 : ST_T0;
            ST_T6:    state <= ST_T0;
            ST_HALTED: state <= ST_HALTED;
            default:  state <= ST_RESET;
         endcase
      end
   end

   // IR fields are only consulted in T3-T6, after the fetch has landed.
   always_comb begin
      PCin = 1'b0;  PCout = 1'b0;  MARin = 1'b0;  MDRin = 1'b0;
      MDRout = 1'b0;  IRin = 1'b0;  Yin = 1'b0;  Zlowin = 1'b0;
      Zhighin = 1'b0;  Zlowout = 1'b0;  Zhighout = 1'b0;
      HIin = 1'b0;  LOin = 1'b0;  IncPC = 1'b0;  Read = 1'b0;
      ALUop = ALU_ADD;
      Run = (state != ST_RESET) && (state != ST_HALTED);
      rin_en = 1'b0;  rin_idx = ra;
      rout_en = 1'b0; rout_idx = rb;
      case (state)
         ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
         ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         ST_T3: begin
            case (cls)
               CLS_ALU2:   begin rout_en = 1'b1; Yin = 1'b1; end
               CLS_UNARY:  begin rout_en = 1'b1; ALUop = op_alu(IR[31:27]); Zlowin = 1'b1; end
               CLS_MULDIV: begin rout_en = 1'b1; rout_idx = ra; Yin = 1'b1; end
               default: ;
            endcase
         end
         ST_T4: begin
            case (cls)
               CLS_ALU2: begin
                  rout_en = 1'b1; rout_idx = rc;
                  ALUop = op_alu(IR[31:27]); Zlowin = 1'b1;
               end
               CLS_UNARY: begin Zlowout = 1'b1; rin_en = 1'b1; end
               CLS_MULDIV: begin
                  rout_en = 1'b1;
                  ALUop = op_alu(IR[31:27]); Zlowin = 1'b1; Zhighin = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            if (cls == CLS_ALU2) begin
               Zlowout = 1'b1; rin_en = 1'b1;
            end else if (cls == CLS_MULDIV) begin
               Zlowout = 1'b1; LOin = 1'b1;
            end
         end
         ST_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
         default: ;
      endcase
   end

   reg_select #(.NUM_REGS(NUM_REGS)) u_rin_sel (
      .en  (rin_en),
      .idx (rin_idx),
      .sel (Rin)
   );

   reg_select #(.NUM_REGS(NUM_REGS)) u_rout_sel (
      .en  (rout_en),
      .idx (rout_idx),
      .sel (Rout)
   );

endmodule
